// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern engine.
//   mode_t    : pattern select as carried on the mode input
//   BAR_TABLE : on/off per channel {R,G,B} for each of the eight colour bars
//   CNT_W     : width of the pixel/line counters (matches the 10-bit x/y outputs)
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_t;

  // Counters are 10 bits wide, so H_TOTAL and V_TOTAL must not exceed 1024.
  localparam int CNT_W = 10;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pin-level bundle of the VGA test-pattern engine.
//   mode, sw_red/green/blue   : control side -> engine (pattern select, solid colour)
//   r/g/b_port, h_sync, v_sync, DE, x_pixel, y_pixel, frame_start : engine -> connector
// There is no valid/ready handshake: the control inputs are level signals that the
// engine samples only on the first pixel tick of each frame, and every output is a
// free-running registered video signal that changes only on pixel ticks
// (frame_start excepted, which is a single-clk pulse).
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4
);
  logic [1:0]         mode;
  logic [COLOR_W-1:0] sw_red;
  logic [COLOR_W-1:0] sw_green;
  logic [COLOR_W-1:0] sw_blue;
  logic [COLOR_W-1:0] r_port;
  logic [COLOR_W-1:0] g_port;
  logic [COLOR_W-1:0] b_port;
  logic               h_sync;
  logic               v_sync;
  logic               DE;
  logic [9:0]         x_pixel;
  logic [9:0]         y_pixel;
  logic               frame_start;

  // Control side: selects the pattern and consumes the video signals.
  modport master (
    output mode, sw_red, sw_green, sw_blue,
    input  r_port, g_port, b_port, h_sync, v_sync, DE, x_pixel, y_pixel, frame_start
  );

  // Engine side.
  modport slave (
    input  mode, sw_red, sw_green, sw_blue,
    output r_port, g_port, b_port, h_sync, v_sync, DE, x_pixel, y_pixel, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider and raw raster decode.
//   clk, reset        : system clock, asynchronous active-high reset
//   tick_o            : one-clk pixel enable (every CLK_DIV clks)
//   h_cnt_o, v_cnt_o  : current column / line
//   visible_o         : (h,v) lies in the visible area
//   hsync_act_o, vsync_act_o : inside the sync pulse (polarity-free)
//   frame_start_o     : tick at (0,0)
// All decode outputs are combinational from the counters; the caller registers them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             visible_o,
  output logic             hsync_act_o,
  output logic             vsync_act_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  // A one-wide counter that never leaves 0 gives a permanent tick for CLK_DIV=1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign tick_o        = tick;
  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign visible_o     = (h_q < H_VIS) && (v_q < V_VIS);
  assign hsync_act_o   = (h_q >= HS_START) && (h_q < HS_END);
  assign vsync_act_o   = (v_q >= VS_START) && (v_q < VS_END);
  assign frame_start_o = tick && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern engine.
//   clk, reset : system clock, asynchronous active-high reset
//   vga        : slave side of vga_pattern_gen_if (mode/solid colour in, video out)
// Mode and solid colour are captured at each frame start, so a whole frame is always
// drawn with one setting. Every video output is registered on the pixel tick and
// therefore trails the raster counters by exactly one pixel.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COLOR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  vga_pattern_gen_if.slave  vga
);

  localparam int BAR_W = (H_VISIBLE >= 8) ? (H_VISIBLE / 8) : 1;
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             visible;
  logic             hs_act;
  logic             vs_act;
  logic             fs_raw;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_VISIBLE(H_VISIBLE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_VISIBLE(V_VISIBLE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .tick_o       (tick),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .visible_o    (visible),
    .hsync_act_o  (hs_act),
    .vsync_act_o  (vs_act),
    .frame_start_o(fs_raw)
  );

  mode_t              mode_q, mode_d;
  logic [COLOR_W-1:0] sw_r_q, sw_r_d;
  logic [COLOR_W-1:0] sw_g_q, sw_g_d;
  logic [COLOR_W-1:0] sw_b_q, sw_b_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               fs_q, fs_d;

  logic [CNT_W-1:0]   bar_quot;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] ramp;
  logic               check_on;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    mode_d = mode_q;
    sw_r_d = sw_r_q;
    sw_g_d = sw_g_q;
    sw_b_d = sw_b_q;
    // The pixel at (0,0) is drawn on the capture tick, so it already uses the
    // freshly sampled settings through the _d values below.
    if (fs_raw) begin
      mode_d = mode_t'(vga.mode);
      sw_r_d = vga.sw_red;
      sw_g_d = vga.sw_green;
      sw_b_d = vga.sw_blue;
    end

    bar_quot = h_cnt / BAR_W_C;
    // Saturation covers H_VISIBLE not divisible by 8 (leftover columns stay black).
    bar_idx  = (bar_quot > CNT_W'(7)) ? 3'd7 : bar_quot[2:0];
    bar_rgb  = BAR_TABLE[bar_idx];
    ramp     = COLOR_W'(h_cnt[9:6]);
    check_on = h_cnt[5] ^ v_cnt[5];

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_d)
      MODE_SOLID: begin
        pix_r = sw_r_d;
        pix_g = sw_g_d;
        pix_b = sw_b_d;
      end
      MODE_BARS: begin
        pix_r = {COLOR_W{bar_rgb[2]}};
        pix_g = {COLOR_W{bar_rgb[1]}};
        pix_b = {COLOR_W{bar_rgb[0]}};
      end
      MODE_CHECK: begin
        pix_r = {COLOR_W{check_on}};
        pix_g = {COLOR_W{check_on}};
        pix_b = {COLOR_W{check_on}};
      end
      MODE_RAMP: begin
        pix_r = ramp;
        pix_g = ramp;
        pix_b = ramp;
      end
      default: ;
    endcase

    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    x_d  = x_q;
    y_d  = y_q;
    if (tick) begin
      r_d  = visible ? pix_r : '0;
      g_d  = visible ? pix_g : '0;
      b_d  = visible ? pix_b : '0;
      hs_d = hs_act ? SYNC_POL : ~SYNC_POL;
      vs_d = vs_act ? SYNC_POL : ~SYNC_POL;
      de_d = visible;
      x_d  = h_cnt;
      y_d  = v_cnt;
    end
    // Updated every clk so that it stays high for a single clk only.
    fs_d = fs_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_SOLID;
      sw_r_q <= '0;
      sw_g_q <= '0;
      sw_b_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sw_r_q <= sw_r_d;
      sw_g_q <= sw_g_d;
      sw_b_q <= sw_b_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
    end
  end

  assign vga.r_port      = r_q;
  assign vga.g_port      = g_q;
  assign vga.b_port      = b_q;
  assign vga.h_sync      = hs_q;
  assign vga.v_sync      = vs_q;
  assign vga.DE          = de_q;
  assign vga.x_pixel     = x_q;
  assign vga.y_pixel     = y_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two instances share the control inputs, one with a
// clock divider of 2 and active-low sync, one with divider 1 and active-high sync.
// A small raster (164-wide visible area, so the last bar saturates) keeps frames short.
// The reference model works from the number of clks since reset release: it derives
// the pixel index by division, and from that the column, line and frame.
module tb_vga_pattern_gen;

  localparam int HV = 164, HFP = 4, HS = 8, HBP = 4;
  localparam int VV = 40,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int DIV_A = 2, DIV_B = 1;
  localparam int CW = 4;
  localparam int FRAME_A = HT * VT * DIV_A;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
  } vid_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    mode_in = 2'd0;
  logic [CW-1:0] sr_in = 4'hF, sg_in = 4'h0, sb_in = 4'h0;

  vga_pattern_gen_if #(.COLOR_W(CW)) if_a ();
  vga_pattern_gen_if #(.COLOR_W(CW)) if_b ();

  assign if_a.mode = mode_in;  assign if_b.mode = mode_in;
  assign if_a.sw_red = sr_in;  assign if_b.sw_red = sr_in;
  assign if_a.sw_green = sg_in; assign if_b.sw_green = sg_in;
  assign if_a.sw_blue = sb_in; assign if_b.sw_blue = sb_in;

  vga_pattern_gen #(
    .CLK_DIV(DIV_A), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0), .COLOR_W(CW)
  ) dut_a (.clk(clk), .reset(reset), .vga(if_a.slave));

  vga_pattern_gen #(
    .CLK_DIV(DIV_B), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1), .COLOR_W(CW)
  ) dut_b (.clk(clk), .reset(reset), .vga(if_b.slave));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Colour of one visible pixel for the captured settings {mode, R, G, B}.
  function automatic logic [11:0] pix(input int h, input int v, input logic [13:0] lat);
    logic [11:0] res;
    logic [3:0]  c;
    int          idx;
    res = 12'h000;
    case (lat[13:12])
      2'd0: res = lat[11:0];
      2'd1: begin
        idx = h / (HV / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: res = 12'hFFF;
          1: res = 12'hFF0;
          2: res = 12'h0FF;
          3: res = 12'h0F0;
          4: res = 12'hF0F;
          5: res = 12'hF00;
          6: res = 12'h00F;
          default: res = 12'h000;
        endcase
      end
      2'd2: res = ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      default: begin
        c   = 4'((h / 64) % 16);
        res = {c, c, c};
      end
    endcase
    return res;
  endfunction

  // Expected outputs n clks after reset release (n=0 while reset is held).
  task automatic model(input int div, input int n, input bit spol,
                       inout logic [13:0] lat, output vid_t e, output bit xyv);
    int k, p, h, v;
    bit fs_now;
    e.rgb = 12'h000; e.hs = ~spol; e.vs = ~spol; e.de = 1'b0; e.fs = 1'b0;
    e.x = 10'd0; e.y = 10'd0;
    xyv = 1'b1;
    k = n / div;
    if (k > 0) begin
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      fs_now = ((n % div) == 0) && (h == 0) && (v == 0);
      if (fs_now) lat = {mode_in, sr_in, sg_in, sb_in};
      e.fs  = fs_now;
      e.de  = (h < HV) && (v < VV);
      e.hs  = (h >= HV + HFP && h < HV + HFP + HS) ? spol : ~spol;
      e.vs  = (v >= VV + VFP && v < VV + VFP + VS) ? spol : ~spol;
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.rgb = e.de ? pix(h, v, lat) : 12'h000;
      xyv   = e.de;
    end
  endtask

  task automatic check_vid(input string who, input vid_t o, input vid_t e, input bit xyv);
    check({who, ".rgb"}, 32'(o.rgb), 32'(e.rgb));
    check({who, ".hs_vs_de_fs"}, 32'({o.hs, o.vs, o.de, o.fs}), 32'({e.hs, e.vs, e.de, e.fs}));
    if (xyv) begin
      check({who, ".x"}, 32'(o.x), 32'(e.x));
      check({who, ".y"}, 32'(o.y), 32'(e.y));
    end
  endtask

  vid_t oa, ea, ob, eb;
  bit xyv_a, xyv_b;
  logic [13:0] lat_a = '0, lat_b = '0;
  int n_a = 0, n_b = 0;
  int last_fs_a = -1, last_fs_b = -1;
  int hs_cnt_a = 0, vs_cnt_a = 0, de_cnt_a = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      n_a = 0; n_b = 0; last_fs_a = -1; last_fs_b = -1;
    end else begin
      n_a++; n_b++;
    end
    oa.rgb = {if_a.r_port, if_a.g_port, if_a.b_port};
    oa.hs = if_a.h_sync; oa.vs = if_a.v_sync; oa.de = if_a.DE; oa.fs = if_a.frame_start;
    oa.x = if_a.x_pixel; oa.y = if_a.y_pixel;
    ob.rgb = {if_b.r_port, if_b.g_port, if_b.b_port};
    ob.hs = if_b.h_sync; ob.vs = if_b.v_sync; ob.de = if_b.DE; ob.fs = if_b.frame_start;
    ob.x = if_b.x_pixel; ob.y = if_b.y_pixel;

    model(DIV_A, n_a, 1'b0, lat_a, ea, xyv_a);
    model(DIV_B, n_b, 1'b1, lat_b, eb, xyv_b);
    check_vid("A", oa, ea, xyv_a);
    check_vid("B", ob, eb, xyv_b);

    if (!reset) begin
      // Whole-frame totals between consecutive frame_start pulses.
      if (oa.fs) begin
        if (last_fs_a >= 0) begin
          check("A.frame_clks", 32'(n_a - last_fs_a), 32'(FRAME_A));
          check("A.hsync_clks", 32'(hs_cnt_a), 32'(VT * HS * DIV_A));
          check("A.vsync_clks", 32'(vs_cnt_a), 32'(VS * HT * DIV_A));
          check("A.de_clks", 32'(de_cnt_a), 32'(VV * HV * DIV_A));
        end
        last_fs_a = n_a;
        hs_cnt_a = 0; vs_cnt_a = 0; de_cnt_a = 0;
      end
      if (!oa.hs) hs_cnt_a++;
      if (!oa.vs) vs_cnt_a++;
      if (oa.de) de_cnt_a++;
      if (ob.fs) begin
        if (last_fs_b >= 0) check("B.frame_clks", 32'(n_b - last_fs_b), 32'(HT * VT * DIV_B));
        last_fs_b = n_b;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic random_settings();
    mode_in = 2'($urandom_range(0, 3));
    sr_in   = 4'($urandom);
    sg_in   = 4'($urandom);
    sb_in   = 4'($urandom);
  endtask

  task automatic random_run(input int changes);
    for (int i = 0; i < changes; i++) begin
      repeat ($urandom_range(100, 600)) @(negedge clk);
      random_settings();
    end
  endtask

  initial begin
    // Reset held for 5 clks with solid red selected.
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Change to checkerboard part-way into the first frame; it must wait for the next one.
    repeat (20 * HT * DIV_A) @(negedge clk);
    mode_in = 2'd2;
    repeat (FRAME_A) @(negedge clk);
    mode_in = 2'd1;
    repeat (FRAME_A / 2) @(negedge clk);

    random_run(30);

    // Asynchronous reset in the middle of a line.
    repeat ($urandom_range(50, 150)) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async.A.rgb", 32'({if_a.r_port, if_a.g_port, if_a.b_port}), 32'h0);
    check("async.A.hs_vs_de_fs", 32'({if_a.h_sync, if_a.v_sync, if_a.DE, if_a.frame_start}), 32'b1100);
    check("async.A.xy", 32'({if_a.x_pixel, if_a.y_pixel}), 32'h0);
    check("async.B.rgb", 32'({if_b.r_port, if_b.g_port, if_b.b_port}), 32'h0);
    check("async.B.hs_vs_de_fs", 32'({if_b.h_sync, if_b.v_sync, if_b.DE, if_b.frame_start}), 32'b0000);
    check("async.B.xy", 32'({if_b.x_pixel, if_b.y_pixel}), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    random_run(20);
    repeat (FRAME_A + 50) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
